// File: rtl/johnson_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : johnson_step_controller
// Description : Command-driven sequencer for a WIDTH-bit Johnson counter
//               (2*WIDTH states). Accepts STOP / STEP-N / RUN / LOAD over a
//               valid/ready handshake and pulses done on command completion.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_step_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active low
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_n,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic             dir_q;
  logic [CNT_W-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH-1:0] adv_d;
  logic [WIDTH-1:0] load_val_d;
  logic             load_ok_d;
  logic             accept_d;

  // A Johnson code has at most one boundary between its run of ones and its
  // run of zeros; any second adjacent-bit change makes it unreachable.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    int changes;
    changes = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) changes++;
    end
    return (changes <= 1);
  endfunction

  // Commands are only refused while a STEP burst is executing.
  assign cmd_ready = (state_q != S_STEP);
  assign accept_d  = cmd_valid && cmd_ready;

  // Next Johnson code in the latched direction and the LOAD target check.
  always_comb begin
    adv_d      = dir_q ? {~out_q[0], out_q[WIDTH-1:1]}
                       : {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
    load_val_d = cmd_n[WIDTH-1:0];
    load_ok_d  = is_legal(load_val_d);
  end

  // Sequencer: state, counter register, latched command fields and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Clear first so that a same-edge illegal LOAD below takes priority.
      if (err_clr) err_q <= 1'b0;

      unique case (state_q)
        S_STEP: begin
          out_q <= adv_d;
          rem_q <= rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        S_IDLE, S_RUN: begin
          if (accept_d) begin
            // The acceptance edge never advances the counter.
            unique case (cmd_op)
              OP_STOP: begin
                if (state_q == S_RUN) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
              OP_STEP: begin
                if (cmd_n == '0) begin
                  // Zero-length step completes immediately without moving.
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  rem_q   <= cmd_n;
                  dir_q   <= cmd_dir;
                  state_q <= S_STEP;
                  busy_q  <= 1'b1;
                end
              end
              OP_RUN: begin
                dir_q   <= cmd_dir;
                state_q <= S_RUN;
                busy_q  <= 1'b1;
              end
              OP_LOAD: begin
                if (load_ok_d) begin
                  out_q <= load_val_d;
                end else begin
                  out_q <= '0;
                  err_q <= 1'b1;
                end
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
              default: ;
            endcase
          end else if (state_q == S_RUN) begin
            out_q <= adv_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_step_controller
// Description : Scoreboard bench for johnson_step_controller. The driver
//               feeds a position-based reference model and queues expected
//               outputs; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_step_controller;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int NS = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_n = '0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  out;
  logic          busy;
  logic          done;
  logic          err;

  johnson_step_controller #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_n     (cmd_n),
    .err_clr   (err_clr),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         err;
    logic         ready;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: the counter is a position 0..2W-1 on the Johnson ring.
  int m_idx, m_st, m_dir, m_rem, m_err, m_done;
  bit m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position i has i ones filling from the LSB, then zeros filling from the LSB.
  function automatic logic [W-1:0] code(input int i);
    logic [31:0] t;
    if (i < W) t = (32'd1 << i) - 32'd1;
    else       t = ~((32'd1 << (i - W)) - 32'd1);
    return t[W-1:0];
  endfunction

  function automatic int find_code(input logic [W-1:0] v);
    for (int i = 0; i < NS; i++) if (code(i) == v) return i;
    return -1;
  endfunction

  function automatic int step_pos(input int i, input int d);
    return d ? (i + NS - 1) % NS : (i + 1) % NS;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_st = 0; m_dir = 0; m_rem = 0; m_err = 0; m_done = 0;
  endtask

  // m_st: 0 idle, 1 stepping, 2 running
  task automatic model_edge(input bit v, input bit [1:0] op, input bit d,
                            input int n, input bit clr);
    int li;
    bit set_err;
    exp_t e;
    set_err = 0;
    m_done  = 0;
    m_acc   = v && (m_st != 1);
    if (m_st == 1) begin
      m_idx = step_pos(m_idx, m_dir);
      m_rem = m_rem - 1;
      if (m_rem == 0) begin m_st = 0; m_done = 1; end
    end else if (m_acc) begin
      case (op)
        2'd0: if (m_st == 2) begin m_st = 0; m_done = 1; end
        2'd1: if (n == 0) begin m_st = 0; m_done = 1; end
              else begin m_rem = n; m_dir = d; m_st = 1; end
        2'd2: begin m_dir = d; m_st = 2; end
        default: begin
          li = find_code(W'(n % (1 << W)));
          if (li < 0) begin m_idx = 0; set_err = 1; end
          else m_idx = li;
          m_st = 0; m_done = 1;
        end
      endcase
    end else if (m_st == 2) begin
      m_idx = step_pos(m_idx, m_dir);
    end
    if (clr) m_err = 0;
    if (set_err) m_err = 1;
    e.out = code(m_idx); e.busy = (m_st != 0); e.done = m_done[0];
    e.err = m_err[0]; e.ready = (m_st != 1);
    q.push_back(e);
  endtask

  // One clock: drive inputs, predict the edge, then land #1 after it.
  task automatic cyc(input bit v, input bit [1:0] op, input bit d,
                     input int n, input bit clr);
    cmd_valid = v; cmd_op = op; cmd_dir = d; cmd_n = CW'(n); err_clr = clr;
    model_edge(v, op, d, n, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 2'd0, 0, 0, 0);
  endtask

  // Holds cmd_valid until the command is taken (bounded).
  task automatic issue(input bit [1:0] op, input bit d, input int n, input bit clr);
    for (int k = 0; k < 64; k++) begin
      cyc(1, op, d, n, clr);
      if (m_acc) begin
        cmd_valid = 0; err_clr = 0;
        return;
      end
    end
    cmd_valid = 0;
    chk("issue_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compares every post-edge observation with the queued prediction.
  always @(negedge clk) begin
    if (rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("mon_out",   32'(out),       32'(e.out));
      chk("mon_busy",  32'(busy),      32'(e.busy));
      chk("mon_done",  32'(done),      32'(e.done));
      chk("mon_err",   32'(err),       32'(e.err));
      chk("mon_ready", 32'(cmd_ready), 32'(e.ready));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out",  32'(out),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    #2 rst = 1'b1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // Async reset while running
    issue(2'd2, 0, 0, 0);
    idle(3);
    #2 rst = 1'b0;
    q.delete();
    #1;
    chk("arst_out",  32'(out),  32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    chk("arst_ready", 32'(cmd_ready), 32'd1);

    // STEP up N=10 from 0000: wraps and ends at 0011
    issue(2'd1, 0, 10, 0);
    idle(9);
    chk("step10_busy", 32'(busy), 32'd1);
    idle(1);
    chk("step10_out",  32'(out),  32'h3);
    chk("step10_busy_end", 32'(busy), 32'd0);
    chk("step10_done", 32'(done), 32'd1);
    idle(1);
    chk("step10_done_once", 32'(done), 32'd0);

    // A command held during STEP waits for IDLE
    issue(2'd1, 0, 4, 0);
    issue(2'd1, 0, 0, 0);
    idle(2);

    // STEP down N=3 from 0000, then STEP N=0
    issue(2'd3, 0, 0, 0);
    issue(2'd1, 1, 3, 0);
    idle(1); chk("down_1", 32'(out), 32'h8);
    idle(1); chk("down_2", 32'(out), 32'hC);
    idle(1); chk("down_3", 32'(out), 32'hE);
    chk("down_done", 32'(done), 32'd1);
    issue(2'd1, 0, 0, 0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_out",  32'(out),  32'hE);

    // RUN up, STOP after 5 advances
    issue(2'd3, 0, 0, 0);
    issue(2'd2, 0, 0, 0);
    idle(5);
    issue(2'd0, 0, 0, 0);
    chk("stop_out",  32'(out),  32'hE);
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_busy", 32'(busy), 32'd0);
    idle(1);
    chk("stop_hold", 32'(out),  32'hE);

    // LOAD legality and err behaviour
    issue(2'd3, 0, 5, 0);
    chk("ld5_out", 32'(out), 32'h0);
    chk("ld5_err", 32'(err), 32'd1);
    issue(2'd3, 0, 7, 0);
    chk("ld7_out", 32'(out), 32'h7);
    chk("ld7_err", 32'(err), 32'd1);
    cyc(0, 2'd0, 0, 0, 1);
    chk("clr_err", 32'(err), 32'd0);
    issue(2'd3, 0, 10, 1);
    chk("ld10_err", 32'(err), 32'd1);
    chk("ld10_out", 32'(out), 32'h0);

    // RUN up from 0001, then STEP N=2 down
    issue(2'd3, 0, 1, 0);
    issue(2'd2, 0, 0, 0);
    idle(2);
    issue(2'd1, 1, 2, 0);
    chk("sw_out",  32'(out),  32'h7);
    chk("sw_done", 32'(done), 32'd0);
    idle(1); chk("sw_1", 32'(out), 32'h3);
    idle(1); chk("sw_2", 32'(out), 32'h1);
    chk("sw_done_end", 32'(done), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit [1:0] op;
      int n;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3) n = ($urandom_range(0, 1) != 0) ? int'(code($urandom_range(0, NS - 1)))
                                                      : $urandom_range(0, 15);
      else n = $urandom_range(0, 12);
      cyc(bit'($urandom_range(0, 2) == 0), op, bit'($urandom_range(0, 1)), n,
          bit'($urandom_range(0, 15) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/johnson_step_controller.md
Name: johnson_step_controller

Overview:
Command-driven sequencer for a WIDTH-bit Johnson counter with 2*WIDTH states. It owns the Johnson register and accepts STOP, STEP-N, RUN and LOAD commands over a valid/ready handshake. Commands can run the counter up or down, and each command completion is signalled. It sits between control logic and any datapath that uses the Johnson code as a phase or slot index.

Parameters:
WIDTH, 4, Johnson register width; state count is 2*WIDTH.
CNT_W, 8, width of the step-count field cmd_n; CNT_W >= WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 STOP, 01 STEP, 10 RUN, 11 LOAD
cmd_dir  input  1  0 up, 1 down; latched at acceptance
cmd_n  input  CNT_W  STEP: advance count; LOAD: bits [WIDTH-1:0] are the load value
err_clr  input  1  clears err
out  output  WIDTH  Johnson counter value
busy  output  1  high when the state is STEP or RUN
done  output  1  one-cycle completion pulse
err  output  1  sticky flag: illegal LOAD value seen

Behaviour:
- Reset (rst=0, async, no clock needed):
  - out=0, state IDLE, busy=0, done=0, err=0.
  - Latched dir=0, remaining count=0.
  - Any in-flight command is discarded.
- Advance up: out <= {out[WIDTH-2:0], ~out[WIDTH-1]}.
  - WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000, then wraps to 0000.
- Advance down: out <= {~out[0], out[WIDTH-1:1]}, the exact reverse sequence. 0000 goes to 1000.
- Legal code: out[i]!=out[i+1] for at most one i in 0..WIDTH-2, which gives exactly 2*WIDTH codes.
- Handshake:
  - Acceptance happens at a rising edge where cmd_valid && cmd_ready.
  - cmd_ready=1 in IDLE and RUN, 0 in STEP.
  - Unaccepted commands have no effect. The requester holds cmd_valid until accepted.
- The acceptance edge never advances out. The only exception is LOAD, which writes out at that edge.
- FSM states: IDLE, STEP, RUN.
- IDLE:
  - STOP: no effect, no done.
  - STEP with N=0: done=1 after the acceptance edge, no advance, remain IDLE.
  - STEP with N>0: remaining=N, go STEP.
  - RUN: go RUN.
  - LOAD: see LOAD below; remain IDLE, done=1.
- STEP:
  - At each edge: advance in the latched dir and decrement remaining.
  - On the edge with remaining==1: go IDLE and set done=1.
  - out advances exactly N times on edges k+1..k+N (k = acceptance edge). busy is high for exactly N cycles.
- RUN:
  - Advance every edge, starting k+1, wrapping indefinitely.
  - A command accepted in RUN suppresses the advance on its acceptance edge.
  - STOP: go IDLE, done=1, out holds its value.
  - STEP: reload remaining and dir, go STEP, no done.
  - RUN: relatch dir, stay RUN.
  - LOAD: go IDLE, done=1.
- LOAD:
  - Value legal: out <= value.
  - Value illegal: out <= 0 and err <= 1.
  - A LOAD of a legal value does not alter err.
- err:
  - Cleared by err_clr=1 at an edge.
  - Set and clear on the same edge: set wins.
- done:
  - Registered, high for exactly one cycle per completion.
  - Never high while busy=1, except on the STEP-to-IDLE edge where busy falls as done rises.
- busy is a registered decode of the state: 1 in STEP and RUN.

Test Plan:
1. Async reset: in RUN, drive rst=0 mid-cycle -> out=0000, busy=0, done=0 before the next clk edge. Release rst -> IDLE, cmd_ready=1.
2. STEP up: from 0000, STEP N=10 dir=0 -> out passes through all 8 codes, wraps, and ends at 0011. busy=1 for exactly 10 cycles, then a single done pulse. cmd_valid held during STEP is not accepted until IDLE.
3. STEP down and N=0: from 0000, STEP N=3 dir=1 -> 1000, 1100, 1110, then done. STEP N=0 -> one done pulse, out unchanged, busy never 1.
4. RUN/STOP: from 0000, RUN dir=0, STOP accepted after 5 advances -> out=1110, held. On the STOP acceptance edge there is no advance; done=1 for one cycle, busy=0.
5. LOAD legality: LOAD 0101 -> out=0000, err=1. LOAD 0111 -> out=0111, err stays 1. err_clr -> err=0. err_clr on the same edge as LOAD 1010 -> err=1.
6. Command switch in RUN: RUN dir=0 from 0001, then STEP N=2 dir=1 accepted -> no advance on the acceptance edge, then two down-advances, then done. No done at the RUN-to-STEP switch.
